// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler
//   Demand-actuated round-robin phase scheduler for a four-road intersection.
//   Detector requests are latched into pending. One road at a time is granted
//   and taken through GREEN -> YELLOW -> ALL_RED. The per-road lights go to a
//   light driver that fans them out to the road's L/S/R heads.
//
//   Optional feature macro: TRAFFIC_EMERG_PREEMPT_EN (emergency preemption).
//   When it is undefined, emerg_req and emerg_road are ignored and
//   emerg_active is tied low.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   synchronous, active-high reset
//   req[3:0]     in   detector request per road (bit i = road i+1)
//   emerg_req    in   emergency preempt request (level)
//   emerg_road   in   road index of the emergency approach
//   road_green   out  one-hot green per road
//   road_yellow  out  one-hot yellow per road
//   road_red     out  red per road, ~(green | yellow)
//   cur_road     out  road currently or last served
//   phase_start  out  one-cycle pulse on the first GREEN cycle
//   pending      out  latched, unserved requests
//   emerg_active out  preemption is steering the FSM
//
// States
//   ST_ALL_RED | every road red; clearance, then pick the next road
//   ST_GREEN   | cur_road green for MIN_GREEN..MAX_GREEN cycles
//   ST_YELLOW  | cur_road yellow for YELLOW_T cycles

module traffic_phase_scheduler #(
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 10,
  parameter int YELLOW_T  = 3,
  parameter int ALL_RED_T = 2,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       emerg_req,
  input  logic [1:0] emerg_road,
  output logic [3:0] road_green,
  output logic [3:0] road_yellow,
  output logic [3:0] road_red,
  output logic [1:0] cur_road,
  output logic       phase_start,
  output logic [3:0] pending,
  output logic       emerg_active
);

  typedef enum logic [1:0] {
    ST_ALL_RED = 2'd0,
    ST_GREEN   = 2'd1,
    ST_YELLOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MIN_LAST  = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST  = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(ALL_RED_T - 1);
  localparam logic [CNT_W-1:0] TIMER_SAT = '1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] timer;
  logic [1:0]       road_nxt;
  logic [3:0]       pending_nxt;
  logic             grant;
  logic             emerg_act;
  logic [3:0]       cur_mask;
  logic [3:0]       grant_mask;
  logic [3:0]       req_mask;
  logic             others_pending;
  logic             green_done;
  logic             rr_found;
  logic [1:0]       rr_road;

  assign cur_mask       = 4'b0001 << cur_road;
  assign others_pending = |(pending & ~cur_mask);

  // Natural end of green: hard limit reached, or minimum served and
  // somebody else is waiting. Using >= keeps this correct after a
  // preemption hold has pushed the timer past MAX_LAST.
  assign green_done = (timer >= MAX_LAST) ||
                      ((timer >= MIN_LAST) && others_pending);

  // Round-robin search starting at the road after cur_road.
  always_comb begin
    logic [1:0] idx;
    rr_found = 1'b0;
    rr_road  = cur_road;
    for (int k = 1; k <= 4; k++) begin
      idx = 2'(cur_road + 2'(k));
      if (!rr_found && pending[idx]) begin
        rr_found = 1'b1;
        rr_road  = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    road_nxt  = cur_road;
    grant     = 1'b0;
    emerg_act = 1'b0;
    case (state)
      ST_ALL_RED: begin
        if (timer >= AR_LAST) begin
`ifdef TRAFFIC_EMERG_PREEMPT_EN
          if (emerg_req) begin
            state_nxt = ST_GREEN;
            road_nxt  = emerg_road;
            grant     = 1'b1;
            emerg_act = 1'b1;
          end else if (rr_found) begin
            state_nxt = ST_GREEN;
            road_nxt  = rr_road;
            grant     = 1'b1;
          end
`else
          if (rr_found) begin
            state_nxt = ST_GREEN;
            road_nxt  = rr_road;
            grant     = 1'b1;
          end
`endif
        end
      end
      ST_GREEN: begin
`ifdef TRAFFIC_EMERG_PREEMPT_EN
        if (emerg_req && (emerg_road != cur_road)) begin
          state_nxt = ST_YELLOW;
          emerg_act = 1'b1;
        end else if (emerg_req) begin
          emerg_act = 1'b1;
        end else if (green_done) begin
          state_nxt = ST_YELLOW;
        end
`else
        if (green_done) begin
          state_nxt = ST_YELLOW;
        end
`endif
      end
      ST_YELLOW: begin
        if (timer >= YEL_LAST) begin
          state_nxt = ST_ALL_RED;
        end
      end
      default: begin
        state_nxt = ST_ALL_RED;
      end
    endcase
  end

  // The road being served does not re-latch its own request while green;
  // the granted road's bit is cleared on entry, overriding a same-cycle set.
  assign req_mask    = (state == ST_GREEN) ? cur_mask : 4'b0000;
  assign grant_mask  = grant ? (4'b0001 << road_nxt) : 4'b0000;
  assign pending_nxt = (pending | (req & ~req_mask)) & ~grant_mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_ALL_RED;
      timer    <= '0;
      cur_road <= 2'd3;
      pending  <= 4'b0000;
    end else begin
      state    <= state_nxt;
      cur_road <= road_nxt;
      pending  <= pending_nxt;
      if (state_nxt != state) begin
        timer <= '0;
      end else if (timer != TIMER_SAT) begin
        timer <= timer + 1'b1;
      end
    end
  end

  assign road_green  = (state == ST_GREEN)  ? cur_mask : 4'b0000;
  assign road_yellow = (state == ST_YELLOW) ? cur_mask : 4'b0000;
  assign road_red    = ~(road_green | road_yellow);
  assign phase_start = (state == ST_GREEN) && (timer == '0);

`ifdef TRAFFIC_EMERG_PREEMPT_EN
  assign emerg_active = emerg_act;
`else
  logic unused_emerg;
  assign unused_emerg = ^{emerg_req, emerg_road, emerg_act};
  assign emerg_active = 1'b0;
`endif

endmodule
